// File: rtl/wddl_pkg.sv
// Shared WDDL types and phase constants for the single-rail to dual-rail front end.
package wddl_pkg;

    typedef struct packed {
        logic t;
        logic f;
    } dual_rail_t;

    localparam dual_rail_t WDDL_SPACER = '{t: 1'b0, f: 1'b0};

    localparam logic PH_PRECHARGE = 1'b1;
    localparam logic PH_EVALUATE  = 1'b0;

endpackage

// File: rtl/precharge_input.sv
// Converts one single-rail bit into a precharged WDDL pair (0/0 spacer during precharge).
module precharge_input
    import wddl_pkg::*;
(
    input  logic a_i,
    input  logic prechrg_i,
    output logic a_o,
    output logic not_a_o
);

    logic w_eval;

    // Inversion happens only here, before the precharge gate, so downstream rails stay monotonic.
    assign w_eval  = (prechrg_i == PH_EVALUATE);
    assign a_o     = w_eval & a_i;
    assign not_a_o = w_eval & ~a_i;

endmodule

// File: rtl/wddl_precharge_input.sv
// WDDL front end: precharged A/B pairs, WDDL AND stage and dual-rail capture register.
// Optional sticky input-stability checker (err_o) enabled by defining WDDL_STABLE_CHECK_EN.
module wddl_precharge_input
    import wddl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic prechrg_i,
    input  logic a_i,
    input  logic b_i,
    output logic a_o,
    output logic not_a_o,
    output logic and_o,
    output logic nand_o,
    output logic q_o,
`ifdef WDDL_STABLE_CHECK_EN
    output logic qbar_o,
    output logic err_o
`else
    output logic qbar_o
`endif
);

    dual_rail_t w_a;
    dual_rail_t w_b;
    dual_rail_t w_and;
    dual_rail_t r_q;

    precharge_input u_pre_a (
        .a_i       (a_i),
        .prechrg_i (prechrg_i),
        .a_o       (w_a.t),
        .not_a_o   (w_a.f)
    );

    precharge_input u_pre_b (
        .a_i       (b_i),
        .prechrg_i (prechrg_i),
        .a_o       (w_b.t),
        .not_a_o   (w_b.f)
    );

    // Positive-only gates: spacer in gives spacer out, so 1/1 can never appear.
    assign w_and.t = w_a.t & w_b.t;
    assign w_and.f = w_a.f | w_b.f;

    assign a_o     = w_a.t;
    assign not_a_o = w_a.f;
    assign and_o   = w_and.t;
    assign nand_o  = w_and.f;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= WDDL_SPACER;
        end else if (prechrg_i == PH_EVALUATE) begin
            r_q <= w_and;
        end
    end

    assign q_o    = r_q.t;
    assign qbar_o = r_q.f;

`ifdef WDDL_STABLE_CHECK_EN
    logic r_prev_eval;
    logic r_a_s;
    logic r_b_s;
    logic r_err;

    // Error only when two back-to-back edges both fall in evaluate and the operands moved between them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_eval <= 1'b0;
            r_a_s       <= 1'b0;
            r_b_s       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prev_eval <= (prechrg_i == PH_EVALUATE);
            r_a_s       <= a_i;
            r_b_s       <= b_i;
            if (r_prev_eval && (prechrg_i == PH_EVALUATE) &&
                ((a_i != r_a_s) || (b_i != r_b_s))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_wddl_precharge_input.sv
// Self-checking bench for wddl_precharge_input: directed phases plus random phases vs a truth-table model.
module tb_wddl_precharge_input;

    logic clk;
    logic rst;
    logic prechrg_i;
    logic a_i;
    logic b_i;
    logic a_o;
    logic not_a_o;
    logic and_o;
    logic nand_o;
    logic q_o;
    logic qbar_o;
`ifdef WDDL_STABLE_CHECK_EN
    logic err_o;
`endif

    int checks;
    int errors;

    // Reference state: last captured dual-rail value of A AND B.
    logic [1:0] exp_q;

    wddl_precharge_input dut (
        .clk       (clk),
        .rst       (rst),
        .prechrg_i (prechrg_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .a_o       (a_o),
        .not_a_o   (not_a_o),
        .and_o     (and_o),
        .nand_o    (nand_o),
        .q_o       (q_o),
`ifdef WDDL_STABLE_CHECK_EN
        .qbar_o    (qbar_o),
        .err_o     (err_o)
`else
        .qbar_o    (qbar_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected combinational rails straight from the WDDL truth table.
    function automatic logic [3:0] model_comb(input logic pre, input logic a, input logic b);
        logic [1:0] ar;
        logic [1:0] yr;
        if (pre) begin
            ar = 2'b00;
            yr = 2'b00;
        end else begin
            ar = a ? 2'b10 : 2'b01;
            yr = (a && b) ? 2'b10 : 2'b01;
        end
        return {ar, yr};
    endfunction

    // One protocol phase: drive on falling edge, check combinational rails, then check register after rising edge.
    task automatic do_phase(input string tag, input logic pre, input logic a, input logic b);
        logic [3:0] m;
        @(negedge clk);
        prechrg_i = pre;
        a_i       = a;
        b_i       = b;
        #1;
        m = model_comb(pre, a, b);
        check({tag, "_a"},   {a_o, not_a_o}, m[3:2]);
        check({tag, "_and"}, {and_o, nand_o}, m[1:0]);
        @(posedge clk);
        #1;
        if (!pre) exp_q = m[1:0];
        check({tag, "_q"},   {q_o, qbar_o}, exp_q);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_q     = 2'b00;
        rst       = 1'b1;
        prechrg_i = 1'b1;
        a_i       = 1'b1;
        b_i       = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_q", {q_o, qbar_o}, 2'b00);
        check("rst_and", {and_o, nand_o}, 2'b00);
`ifdef WDDL_STABLE_CHECK_EN
        check("rst_err", {1'b0, err_o}, 2'b00);
`endif
        @(negedge clk);
        rst = 1'b0;

        do_phase("pre0", 1'b1, 1'b1, 1'b1);
        do_phase("ev01", 1'b0, 1'b0, 1'b1);
        do_phase("pre1", 1'b1, 1'b0, 1'b1);
        do_phase("ev11", 1'b0, 1'b1, 1'b1);
        do_phase("pre_hold", 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_phase("alt_pre", 1'b1, i[0], ~i[0]);
            do_phase("alt_ev", 1'b0, i[0], ~i[0]);
        end
`ifdef WDDL_STABLE_CHECK_EN
        check("alt_err", {1'b0, err_o}, 2'b00);
`endif

        for (int i = 0; i < 20; i++) begin
            logic ra;
            logic rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            do_phase("rnd_pre", 1'b1, ra, rb);
            do_phase("rnd_ev", 1'b0, ra, rb);
        end

        // Mid-evaluate reset with q_o = 1: register clears at once, combinational rails untouched.
        do_phase("pre_r", 1'b1, 1'b1, 1'b1);
        do_phase("ev_r", 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        exp_q = 2'b00;
        check("midrst_q", {q_o, qbar_o}, exp_q);
        check("midrst_and", {and_o, nand_o}, 2'b10);
        rst = 1'b0;
        do_phase("post_rst_pre", 1'b1, 1'b0, 1'b0);
        do_phase("post_rst_ev", 1'b0, 1'b0, 1'b0);

`ifdef WDDL_STABLE_CHECK_EN
        do_phase("stab_pre", 1'b1, 1'b1, 1'b1);
        do_phase("stab_ev1", 1'b0, 1'b1, 1'b1);
        check("stab_err0", {1'b0, err_o}, 2'b00);
        do_phase("stab_ev2", 1'b0, 1'b0, 1'b1);
        check("stab_err1", {1'b0, err_o}, 2'b01);
        do_phase("stab_hold_pre", 1'b1, 1'b0, 1'b0);
        do_phase("stab_hold_ev", 1'b0, 1'b0, 1'b0);
        check("stab_err_hold", {1'b0, err_o}, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q = 2'b00;
        check("stab_err_clr", {1'b0, err_o}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
